pipelined_rc_adder: RTL and testbench
=====================================

PIPELINED_RC_ADDER -- requirements
Module: pipelined_rc_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/sum width in bits.
REQ-002 SHALL have parameter STAGES, default 4, pipeline depth; WIDTH % STAGES == 0 SHALL hold, else elaboration error.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port in_valid  input  1  operand beat offered.
REQ-006 SHALL have port in_ready  output  1  operand beat accepted when in_valid && in_ready.
REQ-007 SHALL have port a  input  WIDTH  operand A.
REQ-008 SHALL have port b  input  WIDTH  operand B.
REQ-009 SHALL have port cin  input  1  carry-in (ignored when sub=1).
REQ-010 SHALL have port sub  input  1  0 = A+B+cin, 1 = A-B (A + ~B + 1).
REQ-011 SHALL have port out_valid  output  1  result beat valid.
REQ-012 SHALL have port out_ready  input  1  downstream accepts result.
REQ-013 SHALL have port sum  output  WIDTH  result.
REQ-014 SHALL have port cout  output  1  carry-out of MSB (for sub: 1 = no borrow).

Function
REQ-015 SHALL split operands into STAGES slices of SLICE = WIDTH/STAGES bits; stage k adds slice k with carry registered from stage k-1.
REQ-016 SHALL delay not-yet-added operand slices and already-computed sum slices alongside each beat so all bits of a result emerge together.
REQ-017 SHALL present a result exactly STAGES cycles after acceptance when out_ready stays high.
REQ-018 SHALL sustain one accepted beat per cycle with no bubbles while out_ready=1.
REQ-019 SHALL define stall = out_valid && !out_ready; on stall every stage, including valid bits, SHALL hold.
REQ-020 SHALL drive in_ready = !stall (combinational from out_valid, out_ready).
REQ-021 SHALL hold sum, cout, out_valid stable while stalled.
REQ-022 SHALL carry a per-stage valid bit; invalid beats propagate as bubbles, output data for bubbles is don't-care but out_valid=0.
REQ-023 SHALL latch sub per beat so mixed add/sub beats pipeline correctly.
REQ-024 SHALL wrap modulo 2^WIDTH; carry out of MSB only on cout.

Reset
REQ-025 SHALL, on rst_n=0, asynchronously clear all valid bits, out_valid=0, sum=0, cout=0.
REQ-026 SHALL drive in_ready=1 during and immediately after reset.
REQ-027 SHALL discard all in-flight beats on reset mid-operation; no result emerges for them.

Configuration
REQ-028 SHALL, when ADDER_OVERFLOW_EN is defined, add output ovf (1 bit): two's-complement signed overflow of the operation, aligned with sum, reset 0.
REQ-029 SHALL, without ADDER_OVERFLOW_EN, have no ovf port and no overflow logic.

Structure
REQ-030 SHALL place default WIDTH/STAGES constants and function slice_width() in shared package adder_pkg.
REQ-031 SHALL implement each stage's combinational slice add with sub-module rca_slice (parameter SLICE; ports a, b, cin, sum, cout), a ripple chain of full adders.
REQ-032 SHALL contain no latches; all pipeline registers on rst_n async clear.

Verification (WIDTH=16, STAGES=4)
REQ-033 SHALL check a=0xFFFF, b=0x0001, cin=0, sub=0 -> sum=0x0000, cout=1, out_valid 4 cycles after accept.
REQ-034 SHALL check a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, cout=0; then a=0x0007, b=0x0005, sub=1 -> sum=0x0002, cout=1.
REQ-035 SHALL check 8 back-to-back beats a=i, b=0x1000*i, out_ready=1 -> 8 consecutive out_valid cycles, results in order.
REQ-036 SHALL check out_ready=0 for 3 cycles while full -> in_ready=0, sum/cout held, no beat lost or duplicated after release.
REQ-037 SHALL check rst_n pulsed low with 2 beats in flight -> out_valid=0 immediately, neither beat emerges, in_ready=1.
REQ-038 SHALL check with ADDER_OVERFLOW_EN: a=0x7FFF, b=0x0001, sub=0 -> sum=0x8000, ovf=1; a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, ovf=1.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared constants, operation encoding and slicing helper for the pipelined ripple-carry adder.
package adder_pkg;

  localparam int unsigned DefWidth  = 16;
  localparam int unsigned DefStages = 4;

  typedef enum logic {
    OpAdd = 1'b0,
    OpSub = 1'b1
  } op_e;

  function automatic int unsigned slice_width(input int unsigned width, input int unsigned stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/rca_slice.sv
// Combinational ripple chain of full adders covering one pipeline slice.
module rca_slice #(
  parameter int unsigned SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] sum,
  output logic             cout
);

  always_comb begin
    logic carry;
    carry = cin;
    sum   = '0;
    for (int i = 0; i < SLICE; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end

endmodule

// File: rtl/pipelined_rc_adder.sv
// Pipelined ripple-carry add/sub with valid/ready flow control; one slice added per stage.
// Optional signed-overflow output ovf when ADDER_OVERFLOW_EN is defined.
module pipelined_rc_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH  = DefWidth,
  parameter int unsigned STAGES = DefStages
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef ADDER_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned SLICE = slice_width(WIDTH, STAGES);
  localparam int unsigned Last  = STAGES - 1;

  if ((WIDTH % STAGES) != 0) begin : g_bad_cfg
    $error("pipelined_rc_adder: WIDTH must be a multiple of STAGES");
  end

  op_e  op;
  logic stall;

  // Stage inputs: index 0 comes from the ports, index k from stage k-1 registers.
  logic [WIDTH-1:0] st_a   [STAGES];
  logic [WIDTH-1:0] st_b   [STAGES];
  logic [WIDTH-1:0] st_sum [STAGES];
  logic [STAGES-1:0] st_c;
  logic [STAGES-1:0] st_v;

  logic [SLICE-1:0] add_sum [STAGES];
  logic [STAGES-1:0] add_c;
  logic [WIDTH-1:0] sum_d [STAGES];

  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] b_q   [STAGES];
  logic [WIDTH-1:0] sum_q [STAGES];
  logic [STAGES-1:0] c_q;
  logic [STAGES-1:0] v_q;

  assign op       = op_e'(sub);
  assign stall    = v_q[Last] && !out_ready;
  assign in_ready = !stall;

  // B is inverted and carry forced at accept, so each beat carries its own operation downstream.
  always_comb begin
    st_a[0]   = a;
    st_b[0]   = (op == OpSub) ? ~b : b;
    st_c[0]   = (op == OpSub) ? 1'b1 : cin;
    st_sum[0] = '0;
    st_v[0]   = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      st_a[k]   = a_q[k-1];
      st_b[k]   = b_q[k-1];
      st_c[k]   = c_q[k-1];
      st_sum[k] = sum_q[k-1];
      st_v[k]   = v_q[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    rca_slice #(
      .SLICE(SLICE)
    ) u_slice (
      .a   (st_a[k][k*SLICE +: SLICE]),
      .b   (st_b[k][k*SLICE +: SLICE]),
      .cin (st_c[k]),
      .sum (add_sum[k]),
      .cout(add_c[k])
    );
  end

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      sum_d[k]                  = st_sum[k];
      sum_d[k][k*SLICE +: SLICE] = add_sum[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        sum_q[k] <= '0;
      end
      c_q <= '0;
      v_q <= '0;
    end else if (!stall) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= st_a[k];
        b_q[k]   <= st_b[k];
        sum_q[k] <= sum_d[k];
      end
      c_q <= add_c;
      v_q <= st_v;
    end
  end

  assign out_valid = v_q[Last];
  assign sum       = sum_q[Last];
  assign cout      = c_q[Last];

`ifdef ADDER_OVERFLOW_EN
  logic ovf_d;
  logic ovf_q;

  // Operand signs meet the result sign in the last stage, which adds the MSB slice.
  assign ovf_d = (st_a[Last][WIDTH-1] == st_b[Last][WIDTH-1]) &&
                 (add_sum[Last][SLICE-1] != st_a[Last][WIDTH-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (!stall) begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_rc_adder.sv
// Self-checking bench for pipelined_rc_adder (WIDTH=16, STAGES=4); table vectors plus
// back-to-back, stall and mid-flight reset sequences.
module tb_pipelined_rc_adder;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
`ifdef ADDER_OVERFLOW_EN
  logic         ovf;
`endif

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  pipelined_rc_adder #(
    .WIDTH (16),
    .STAGES(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .sub      (sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout)
`ifdef ADDER_OVERFLOW_EN
    ,
    .ovf      (ovf)
`endif
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference result as {cout, sum}.
  function automatic logic [16:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic ci, input logic s);
    if (s) return {1'b0, x} + {1'b0, ~y} + 17'd1;
    else   return {1'b0, x} + {1'b0, y} + {16'd0, ci};
  endfunction

  initial begin
    logic [16:0] exp_q[$];
    logic [16:0] e;
    int lat, first, last, got, drops, nb, nr, cyc;

    //           a         b         cin   sub   sum       cout  ovf
    vecs[0]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[1]  = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[2]  = '{16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0};
    vecs[3]  = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
    vecs[4]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[5]  = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
    vecs[6]  = '{16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};
    vecs[7]  = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[8]  = '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[9]  = '{16'h1234, 16'h0001, 1'b1, 1'b1, 16'h1233, 1'b1, 1'b0};
    vecs[10] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[11] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;

    #12;
    check("reset_out_valid", out_valid, 0);
    check("reset_sum", sum, 0);
    check("reset_cout", cout, 0);
    check("reset_in_ready", in_ready, 1);
`ifdef ADDER_OVERFLOW_EN
    check("reset_ovf", ovf, 0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1 check("post_reset_in_ready", in_ready, 1);

    // Single beats: latency and result per table entry.
    foreach (vecs[i]) begin
      a = vecs[i].a; b = vecs[i].b; cin = vecs[i].cin; sub = vecs[i].sub; in_valid = 1'b1;
      #1 check($sformatf("vec%0d_in_ready", i), in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 20) begin
        @(posedge clk); #1;
        lat++;
      end
      check($sformatf("vec%0d_latency", i), lat, 4);
      check($sformatf("vec%0d_sum", i), sum, vecs[i].sum);
      check($sformatf("vec%0d_cout", i), cout, vecs[i].cout);
`ifdef ADDER_OVERFLOW_EN
      check($sformatf("vec%0d_ovf", i), ovf, vecs[i].ovf);
`endif
    end
    @(posedge clk); #1;

    // Eight back-to-back beats with out_ready held high.
    first = -1; last = -1; got = 0; drops = 0;
    for (int c = 0; c < 20; c++) begin
      if (c < 8) begin
        a = 16'(c); b = 16'(32'h1000 * c); cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (in_valid && !in_ready) drops++;
      if (out_valid) begin
        if (first < 0) first = c;
        last = c;
        if (got < 8) check($sformatf("b2b_sum%0d", got), sum, 16'(got + 32'h1000 * got));
        got++;
      end
      @(posedge clk); #1;
    end
    check("b2b_first_valid_cycle", first, 4);
    check("b2b_count", got, 8);
    check("b2b_contiguous", last - first, 7);
    check("b2b_in_ready_drops", drops, 0);

    // Stall with a full pipeline for three cycles, then drain eight beats in order.
    nb = 0; nr = 0; cyc = 0;
    while (nr < 8 && cyc < 60) begin
      out_ready = (cyc >= 7);
      if (nb < 8) begin
        a = 16'(32'h0100 * nb + 3); b = 16'(32'h00F0 + nb); cin = 1'b0; sub = nb[0];
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (cyc >= 4 && cyc <= 6) begin
        check($sformatf("stall%0d_in_ready", cyc), in_ready, 0);
        check($sformatf("stall%0d_out_valid", cyc), out_valid, 1);
        check($sformatf("stall%0d_held", cyc), {cout, sum}, exp_q[0]);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("stall_extra_beat", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("stall_beat%0d", nr), {cout, sum}, e);
        end
        nr++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b, cin, sub));
        nb++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    check("stall_received", nr, 8);
    check("stall_leftover", exp_q.size(), 0);
    @(posedge clk); #1;
    check("stall_no_duplicate", out_valid, 0);

    // Reset with two beats in flight, the first one stalled at the output.
    out_ready = 1'b0;
    a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    a = 16'h3333; b = 16'h0001;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check("rst_mid_pre_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_out_valid", out_valid, 0);
    check("rst_mid_sum", sum, 0);
    check("rst_mid_cout", cout, 0);
    check("rst_mid_in_ready", in_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1 check("rst_mid_in_ready_after", in_ready, 1);
    got = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (out_valid) got++;
    end
    check("rst_mid_no_emerge", got, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
